// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch state encoding and default parameter constants
package fetch_pkg;
  typedef enum logic {RUN, HALT} fetch_state_t;
  localparam int          DEF_XLEN         = 32;
  localparam int          DEF_IM_AW        = 8;
  localparam int unsigned DEF_PC_STEP      = 1;
  localparam int unsigned DEF_RESET_PC     = 0;
  localparam int          DEF_HALT_ON_ZERO = 0;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry word+link-PC holding register for responses arriving under stall
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clkd,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [XLEN-1:0] word_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] word,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clkd) begin
    if (rst || clr) valid <= 1'b0;
    else if (load) begin
      valid <= 1'b1;
      word  <= word_in;
      pc    <= pc_in;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with one-cycle memory latency, skid, redirect and halt-on-zero
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          XLEN         = DEF_XLEN,
  parameter int          IM_AW        = DEF_IM_AW,
  parameter int unsigned PC_STEP      = DEF_PC_STEP,
  parameter int unsigned RESET_PC     = DEF_RESET_PC,
  parameter int          HALT_ON_ZERO = DEF_HALT_ON_ZERO
) (
  input  logic             clkd,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_en,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr_out,
  output logic [XLEN-1:0]  pc_out,
  output logic             instr_valid,
  output logic             halted
);
  fetch_state_t state, state_nx;
  logic [XLEN-1:0] pc, pend_pc, link, skid_word, skid_pc;
  logic pend, issue, zero_hit, skid_valid, skid_load, skid_clr;
  always_comb begin
    issue     = !rst && state == RUN && !stall && !redirect_valid;
    zero_hit  = HALT_ON_ZERO != 0 && pend && imem_rdata == '0;
    link      = pend_pc + XLEN'(PC_STEP);
    skid_load = stall && pend && !redirect_valid && !zero_hit;
    skid_clr  = redirect_valid || !stall;
    state_nx  = redirect_valid ? RUN : zero_hit ? HALT : state;
  end
  assign imem_en   = issue;
  assign imem_addr = pc[IM_AW-1:0];
  assign halted    = state == HALT;
  always_ff @(posedge clkd) begin
    if (rst) state <= RUN;
    else state <= state_nx;
  end
  fetch_skid #(.XLEN(XLEN)) u_skid (
    .clkd(clkd), .rst(rst), .clr(skid_clr), .load(skid_load),
    .word_in(imem_rdata), .pc_in(link),
    .valid(skid_valid), .word(skid_word), .pc(skid_pc)
  );
  // a halting word is dropped together with whatever was issued alongside it
  always_ff @(posedge clkd) begin
    if (rst) begin
      pc          <= XLEN'(RESET_PC);
      pend        <= 1'b0;
      pend_pc     <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      pend <= issue && !zero_hit;
      if (issue) begin
        pc      <= pc + XLEN'(PC_STEP);
        pend_pc <= pc;
      end
      if (redirect_valid) begin
        pc          <= redirect_pc;
        instr_valid <= 1'b0;
      end else if (!stall) begin
        if (skid_valid) begin
          instr_out   <= skid_word;
          pc_out      <= skid_pc;
          instr_valid <= 1'b1;
        end else if (pend && !zero_hit) begin
          instr_out   <= imem_rdata;
          pc_out      <= link;
          instr_valid <= 1'b1;
        end else instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus, cycle model from mem contents, literal spot checks
module tb_fetch_stage;
  logic clkd = 1'b0;
  logic rst = 1'b1, stall = 1'b0, rv = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] mem [256];
  logic en0, en1, val0, val1, hal0, hal1;
  logic [7:0] addr0, addr1;
  logic [31:0] rd0, rd1, ins0, ins1, pco0, pco1;
  int checks = 0, errors = 0;

  always #5 clkd = ~clkd;

  fetch_stage #(.HALT_ON_ZERO(1)) u0 (
    .clkd(clkd), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .imem_en(en0), .imem_addr(addr0), .imem_rdata(rd0),
    .instr_out(ins0), .pc_out(pco0), .instr_valid(val0), .halted(hal0)
  );
  fetch_stage #(.HALT_ON_ZERO(0)) u1 (
    .clkd(clkd), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .imem_en(en1), .imem_addr(addr1), .imem_rdata(rd1),
    .instr_out(ins1), .pc_out(pco1), .instr_valid(val1), .halted(hal1)
  );

  always @(posedge clkd) if (en0) rd0 <= mem[addr0];
  always @(posedge clkd) if (en1) rd1 <= mem[addr1];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  // model of u0: a read issued from PC p returns mem[p mod 256] one cycle later
  logic [31:0] m_pc, m_fly_pc, m_held_word, m_held_pc, m_instr, m_pcout;
  bit m_fly, m_held, m_run, m_valid;
  always @(posedge clkd) begin
    if (rst) begin
      m_pc = 0; m_fly = 0; m_held = 0; m_run = 1;
      m_instr = 0; m_pcout = 0; m_valid = 0;
    end else if (rv) begin
      m_pc = rpc; m_fly = 0; m_held = 0; m_valid = 0; m_run = 1;
    end else begin
      automatic bit go = m_run && !stall;
      automatic logic [31:0] w = mem[m_fly_pc[7:0]];
      automatic bit zero = m_fly && w == 0;
      if (zero) m_run = 0;
      if (stall) begin
        if (m_fly && !zero) begin m_held = 1; m_held_word = w; m_held_pc = m_fly_pc + 1; end
      end else if (m_held) begin
        m_instr = m_held_word; m_pcout = m_held_pc; m_valid = 1; m_held = 0;
      end else if (m_fly && !zero) begin
        m_instr = w; m_pcout = m_fly_pc + 1; m_valid = 1;
      end else m_valid = 0;
      m_fly = go && !zero;
      if (go) begin m_fly_pc = m_pc; m_pc = m_pc + 1; end
    end
  end

  always @(posedge clkd) begin
    #1;
    chk("valid", {31'b0, val0}, {31'b0, m_valid});
    chk("halted", {31'b0, hal0}, {31'b0, !m_run});
    chk("imem_en", {31'b0, en0}, {31'b0, !rst && m_run && !stall && !rv});
    chk("imem_addr", {24'b0, addr0}, {24'b0, m_pc[7:0]});
    if (m_valid) begin
      chk("instr_out", ins0, m_instr);
      chk("pc_out", pco0, m_pcout);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clkd);
  endtask

  task automatic out(input string n, input logic [31:0] i, input logic [31:0] p, input logic v);
    chk({n, "_instr"}, ins0, i);
    chk({n, "_pc"}, pco0, p);
    chk({n, "_valid"}, {31'b0, val0}, {31'b0, v});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i + 100;
    step(3);
    out("reset", 0, 0, 0);
    chk("reset_en", {31'b0, en0}, 0);
    rst = 0;
    step(1); chk("lat1_valid", {31'b0, val0}, 0);
    step(1); out("seq0", 100, 1, 1);
    step(1); out("seq1", 101, 2, 1);
    step(1); out("seq2", 102, 3, 1);
    stall = 1;
    for (int k = 0; k < 3; k++) begin step(1); out("frozen", 102, 3, 1); end
    stall = 0;
    step(1); out("skid_rel", 103, 4, 1);
    step(1); out("after_rel", 104, 5, 1);
    stall = 1;
    step(1);
    rv = 1; rpc = 32'h40;
    step(1); chk("redir_valid", {31'b0, val0}, 0);
    rv = 0; stall = 0;
    step(1); chk("no_stale", {31'b0, val0}, 0);
    step(1); out("redir_tgt", 164, 32'h41, 1);
    rv = 1; rpc = 32'hff;
    step(1); rv = 0;
    chk("addr_ff", {24'b0, addr0}, 32'hff);
    step(1); chk("addr_wrap", {24'b0, addr0}, 0);
    step(1); out("wrap0", 355, 32'h100, 1);
    step(1); out("wrap1", 100, 32'h101, 1);
    stall = 1;
    step(1); rst = 1; stall = 0;
    step(1); out("rst_skid", 0, 0, 0);
    rst = 0;
    step(1); chk("rst_noskid", {31'b0, val0}, 0);
    step(1); out("rst_restart", 100, 1, 1);
    rst = 1; mem[5] = 0;
    step(1); rst = 0;
    step(6); out("pre_halt", 104, 5, 1);
    step(1);
    chk("halt_valid", {31'b0, val0}, 0);
    chk("halted", {31'b0, hal0}, 1);
    chk("nohalt_instr", ins1, 0);
    chk("nohalt_pc", pco1, 6);
    chk("nohalt_valid", {31'b0, val1}, 1);
    chk("nohalt_halted", {31'b0, hal1}, 0);
    mem[5] = 105;
    step(3); chk("halt_en", {31'b0, en0}, 0);
    rv = 1; rpc = 0;
    step(1); rv = 0;
    chk("resume_halted", {31'b0, hal0}, 0);
    step(2); out("resume", 100, 1, 1);
    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
